// File: rtl/drum_pkg.sv
// Shared constants and helpers for the three-voice drum synthesiser.
package drum_pkg;

    // Voice slots, also used as bit positions in the active/trigger vectors
    typedef enum logic [1:0] {
        VOICE_SNARE  = 2'd0,
        VOICE_BASS   = 2'd1,
        VOICE_CYMBAL = 2'd2
    } voice_e;

    typedef enum logic {
        ENV_IDLE  = 1'b0,
        ENV_DECAY = 1'b1
    } env_state_e;

    // Samples per amplitude step of each envelope
    localparam int SNARE_DIV  = 24;
    localparam int BASS_DIV   = 48;
    localparam int CYMBAL_DIV = 96;

    // Samples per half period of the 100 Hz bass square wave at 48 kHz
    localparam int BASS_HALF = 240;

    // Galois LFSR for x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Mix weights expressed as left shifts
    localparam int BASS_SHIFT   = 5;
    localparam int SNARE_SHIFT  = 4;
    localparam int CYMBAL_SHIFT = 3;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

    // Unsigned amplitude plus a sign flag turned into a 9-bit signed value
    function automatic logic signed [8:0] signed_amp(input logic [7:0] amp, input logic neg);
        logic signed [8:0] mag;
        mag = $signed({1'b0, amp});
        return neg ? -mag : mag;
    endfunction

endpackage

// File: rtl/drum_voice_env.sv
// Linear-decay envelope for one drum voice: retriggerable, one amplitude
// step every DIV samples, idle once the amplitude reaches zero.
module drum_voice_env
    import drum_pkg::*;
#(
    parameter int DIV = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic       trig,
    output logic [7:0] amp,
    output logic       active
);

    localparam int            DW       = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    env_state_e    state;
    logic [DW-1:0] divider;

    assign active = (state == ENV_DECAY);

    // Envelope FSM: a trigger restarts at full scale, otherwise decay by one step per DIV samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ENV_IDLE;
            amp     <= 8'd0;
            divider <= '0;
        end else if (sample_en) begin
            if (trig) begin
                state   <= ENV_DECAY;
                amp     <= 8'd255;
                divider <= '0;
            end else if (state == ENV_DECAY) begin
                if (divider == DIV_LAST) begin
                    divider <= '0;
                    amp     <= amp - 8'd1;
                    if (amp == 8'd1) begin
                        state <= ENV_IDLE;
                    end
                end else begin
                    divider <= divider + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/drum_voice_synth.sv
// Three-voice drum synthesiser: snare and cymbal are LFSR noise, bass is a
// 100 Hz square wave, each shaped by its own decaying envelope and mixed.
module drum_voice_synth
    import drum_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        sample_en,
    input  logic        snare,
    input  logic        bass,
    input  logic        cymbal,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic [2:0]  active
);

    logic [2:0] trig_in;
    logic [2:0] trig_prev;
    logic [2:0] edges;
    logic [2:0] pending;
    logic [2:0] trig;
    logic       armed;

    logic [7:0] amp_snare;
    logic [7:0] amp_bass;
    logic [7:0] amp_cymbal;

    logic [7:0]  half_cnt;
    logic        phase_neg;
    logic [15:0] lfsr;

    logic signed [8:0]  snare_v;
    logic signed [8:0]  bass_v;
    logic signed [8:0]  cymbal_v;
    logic signed [15:0] mix;

    assign trig_in = {cymbal, bass, snare};
    assign edges   = armed ? (trig_in & ~trig_prev) : 3'b000;
    assign trig    = pending | edges;

    // Edge capture: remember each trigger until the next sample strobe consumes it
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            armed     <= 1'b0;
            trig_prev <= 3'b000;
            pending   <= 3'b000;
        end else begin
            armed     <= 1'b1;
            trig_prev <= trig_in;
            pending   <= sample_en ? 3'b000 : (pending | edges);
        end
    end

    drum_voice_env #(.DIV(SNARE_DIV)) u_env_snare (
        .clk       (Clk),
        .rst       (Reset),
        .sample_en (sample_en),
        .trig      (trig[VOICE_SNARE]),
        .amp       (amp_snare),
        .active    (active[VOICE_SNARE])
    );

    drum_voice_env #(.DIV(BASS_DIV)) u_env_bass (
        .clk       (Clk),
        .rst       (Reset),
        .sample_en (sample_en),
        .trig      (trig[VOICE_BASS]),
        .amp       (amp_bass),
        .active    (active[VOICE_BASS])
    );

    drum_voice_env #(.DIV(CYMBAL_DIV)) u_env_cymbal (
        .clk       (Clk),
        .rst       (Reset),
        .sample_en (sample_en),
        .trig      (trig[VOICE_CYMBAL]),
        .amp       (amp_cymbal),
        .active    (active[VOICE_CYMBAL])
    );

    // Bass square wave: flip polarity every BASS_HALF samples, restart positive on trigger
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            half_cnt  <= 8'd0;
            phase_neg <= 1'b0;
        end else if (sample_en) begin
            if (trig[VOICE_BASS]) begin
                half_cnt  <= 8'd0;
                phase_neg <= 1'b0;
            end else if (active[VOICE_BASS]) begin
                if (half_cnt == 8'(BASS_HALF - 1)) begin
                    half_cnt  <= 8'd0;
                    phase_neg <= ~phase_neg;
                end else begin
                    half_cnt <= half_cnt + 8'd1;
                end
            end
        end
    end

    // Noise source shared by snare and cymbal, stepped once per sample
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lfsr <= LFSR_SEED;
        end else if (sample_en) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Weighted mix of the three voices from the current (pre-strobe) state
    always_comb begin
        snare_v  = signed_amp(amp_snare,  lfsr[0]);
        bass_v   = signed_amp(amp_bass,   phase_neg);
        cymbal_v = signed_amp(amp_cymbal, lfsr[7]);
        mix      = ({{7{bass_v[8]}},   bass_v}   <<< BASS_SHIFT)
                 + ({{7{snare_v[8]}},  snare_v}  <<< SNARE_SHIFT)
                 + ({{7{cymbal_v[8]}}, cymbal_v} <<< CYMBAL_SHIFT);
    end

    // Output register: capture the mix on each strobe and flag it for one cycle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sample_out   <= 16'd0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= sample_en;
            if (sample_en) begin
                sample_out <= mix;
            end
        end
    end

endmodule

// File: tb/tb_drum_voice_synth.sv
// Scoreboard bench for drum_voice_synth: stimulus queues hand-derived
// expected samples, a monitor pops and compares on every sample_valid.
module tb_drum_voice_synth;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sample_en;
    logic        snare;
    logic        bass;
    logic        cymbal;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [2:0]  active;

    typedef struct packed {
        logic        chk;
        logic [15:0] exp;
        logic [7:0]  scen;
        logic [31:0] idx;
    } sb_entry_t;

    sb_entry_t   sb_queue[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [15:0] tb_lfsr;

    drum_voice_synth dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .sample_en    (sample_en),
        .snare        (snare),
        .bass         (bass),
        .cymbal       (cymbal),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .active       (active)
    );

    always #5 Clk = ~Clk;

    // Reference noise generator, stepped once per issued strobe
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    // One weighted voice term: +/-amp scaled by 2^shift, as 16-bit two's complement
    function automatic logic [15:0] term(input int amp, input bit neg, input int shift);
        int v;
        v = neg ? -amp : amp;
        return 16'(v * (1 << shift));
    endfunction

    // Envelope amplitude seen at strobe j, where j=1 is the strobe that took the trigger
    function automatic int env_amp(input int j, input int div);
        int a;
        if (j < 2) return 0;
        a = 255 - (j - 2) / div;
        return (a < 0) ? 0 : a;
    endfunction

    function automatic logic [15:0] bass_term(input int j);
        bit neg;
        neg = (j >= 2) && ((((j - 2) / 240) % 2) == 1);
        return term(env_amp(j, 48), neg, 5);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic chk, input logic [15:0] exp, input int scen,
                                 input int idx, input logic [2:0] trig);
        @(negedge Clk);
        sample_en = 1'b1;
        {cymbal, bass, snare} = trig;
        sb_queue.push_back({chk, exp, 8'(scen), 32'(idx)});
        tb_lfsr = lfsr_step(tb_lfsr);
    endtask

    task automatic idleCycle(input logic [2:0] trig);
        @(negedge Clk);
        sample_en = 1'b0;
        {cymbal, bass, snare} = trig;
    endtask

    task automatic resetDut(input logic [2:0] trig);
        sample_en = 1'b0;
        {cymbal, bass, snare} = trig;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        tb_lfsr = 16'hACE1;
    endtask

    // Monitor: every presented sample is matched against the oldest queued expectation
    always @(negedge Clk) begin
        if (sample_valid) begin
            if (sb_queue.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL scoreboard_underflow: sample 0x%0h with nothing expected", sample_out);
            end else begin
                sb_entry_t e;
                e = sb_queue.pop_front();
                if (e.chk) begin
                    n_checks++;
                    if (sample_out !== e.exp) begin
                        n_fails++;
                        $display("[TB] FAIL sample s%0d k%0d: got %0d, expected %0d",
                                 e.scen, e.idx, $signed(sample_out), $signed(e.exp));
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] e;
        int          t;
        int          zero_count;
        int          period;

        Reset = 1'b0;
        sample_en = 1'b0;
        {cymbal, bass, snare} = 3'b000;
        tb_lfsr = 16'hACE1;
        #2;

        // Reset state
        Reset = 1'b1;
        #3;
        checkOutput("reset_sample_out", 32'(sample_out), 32'd0);
        checkOutput("reset_valid", 32'(sample_valid), 32'd0);
        checkOutput("reset_active", 32'(active), 32'd0);

        // Scenario 1: single bass pulse, decay and square-wave polarity
        $display("[TB] scenario 1: bass pulse");
        resetDut(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b010);
        idleCycle(3'b000);
        for (int k = 1; k <= 250; k++) begin
            e = (k == 1) ? 16'd0 : bass_term(k);
            applyStimulus(1'b1, e, 1, k, 3'b000);
        end
        idleCycle(3'b000);
        checkOutput("s1_active_bass", 32'(active), 32'b010);
        idleCycle(3'b000);
        idleCycle(3'b000);
        checkOutput("s1_hold_between_strobes", 32'(sample_out), 32'(bass_term(250)));
        checkOutput("s1_valid_low_when_idle", 32'(sample_valid), 32'd0);

        // Scenario 2: bass retriggered at strobe 100 and again during negative phase at 350
        $display("[TB] scenario 2: bass retrigger");
        resetDut(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b010);
        idleCycle(3'b000);
        t = 1;
        for (int k = 1; k <= 360; k++) begin
            logic trg;
            trg = (k == 100) || (k == 350);
            e = (k == 1) ? 16'd0 : bass_term(k - t + 1);
            applyStimulus(1'b1, e, 2, k, trg ? 3'b010 : 3'b000);
            if (trg) t = k;
        end
        idleCycle(3'b000);
        idleCycle(3'b000);

        // Scenario 3: snare decays fully without retrigger
        $display("[TB] scenario 3: snare decay");
        resetDut(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b001);
        idleCycle(3'b000);
        for (int k = 1; k <= 6123; k++) begin
            if (k == 6121) begin
                idleCycle(3'b000);
                checkOutput("s3_active_before_end", 32'(active), 32'b001);
            end
            if (k == 6122) begin
                idleCycle(3'b000);
                checkOutput("s3_active_cleared", 32'(active), 32'b000);
            end
            e = (k == 1) ? 16'd0 : term(env_amp(k, 24), tb_lfsr[0], 4);
            applyStimulus(1'b1, e, 3, k, 3'b000);
        end
        idleCycle(3'b000);
        idleCycle(3'b000);

        // Scenario 4: all three voices at once, checking mix weights and noise signs
        $display("[TB] scenario 4: full mix");
        resetDut(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b000);
        idleCycle(3'b111);
        idleCycle(3'b000);
        for (int k = 1; k <= 30; k++) begin
            e = (k == 1) ? 16'd0 : (bass_term(k) + term(env_amp(k, 24), tb_lfsr[0], 4)
                                   + term(env_amp(k, 96), tb_lfsr[7], 3));
            applyStimulus(1'b1, e, 4, k, 3'b000);
        end
        idleCycle(3'b000);
        checkOutput("s4_active_all", 32'(active), 32'b111);
        idleCycle(3'b000);

        // Scenario 5: level held through reset release, then async reset mid-decay
        $display("[TB] scenario 5: reset behaviour");
        resetDut(3'b001);
        idleCycle(3'b001);
        idleCycle(3'b001);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 16'd0, 5, k, 3'b001);
        end
        idleCycle(3'b001);
        checkOutput("s5_held_no_trigger", 32'(active), 32'd0);
        idleCycle(3'b000);
        idleCycle(3'b001);
        idleCycle(3'b000);
        for (int k = 1; k <= 20; k++) begin
            e = (k == 1) ? 16'd0 : term(env_amp(k, 24), tb_lfsr[0], 4);
            applyStimulus(1'b1, e, 6, k, 3'b000);
        end
        idleCycle(3'b000);
        idleCycle(3'b000);
        checkOutput("s5_decaying", 32'(active), 32'b001);
        idleCycle(3'b001);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("s5_async_sample_out", 32'(sample_out), 32'd0);
        checkOutput("s5_async_active", 32'(active), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        snare = 1'b0;
        Reset = 1'b0;
        tb_lfsr = 16'hACE1;
        idleCycle(3'b000);
        idleCycle(3'b000);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 16'd0, 7, k, 3'b000);
        end
        idleCycle(3'b000);
        checkOutput("s5_no_residual", 32'(active), 32'd0);
        idleCycle(3'b000);

        // Scenario 6: noise generator over 70000 strobes
        $display("[TB] scenario 6: noise period");
        resetDut(3'b000);
        zero_count = 0;
        period = 0;
        @(negedge Clk);
        sample_en = 1'b1;
        sb_queue.push_back({1'b0, 16'd0, 8'd8, 32'd0});
        for (int step = 1; step <= 70000; step++) begin
            @(negedge Clk);
            if (dut.lfsr == 16'h0000) zero_count++;
            if (period == 0 && dut.lfsr == 16'hACE1) period = step;
            if (step < 70000) begin
                sb_queue.push_back({1'b0, 16'd0, 8'd8, 32'(step)});
            end else begin
                sample_en = 1'b0;
            end
        end
        checkOutput("s6_lfsr_never_zero", 32'(zero_count), 32'd0);
        checkOutput("s6_lfsr_period", 32'(period), 32'd65535);

        idleCycle(3'b000);
        idleCycle(3'b000);
        checkOutput("scoreboard_drain", 32'(sb_queue.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
